// File: rtl/decimating_output_buffer.sv
// -----------------------------------------------------------------------------
// decimating_output_buffer
//
// Output stage after the symmetric-round stage of the systolic FIR. It keeps
// every N-th rounded sample (runtime factor N), queues kept samples in a small
// show-ahead FIFO, and lets the downstream consumer drain it with valid/ready.
// Kept samples that arrive while the FIFO is full are dropped and flagged.
//
// Optional feature macro: DECIM_BUF_OVF_CNT_EN
//   defined   -> adds OvfCount_o, a 16-bit saturating count of dropped samples
//   undefined -> no counter, no port; Overflow_o behaves identically
//
// Ports:
//   Clk_i          in   clock, rising edge
//   Rst_i          in   synchronous active-high reset
//   Data_i         in   signed sample from the round stage
//   DataNd_i       in   new-data strobe for Data_i
//   DecimFactor_i  in   decimation factor N (0 and 1 keep every sample)
//   Ready_i        in   downstream ready
//   ClearOvf_i     in   clears Overflow_o (and OvfCount_o)
//   Data_o         out  FIFO head sample, 0 while DataValid_o is low
//   DataValid_o    out  FIFO not empty
//   Level_o        out  FIFO occupancy 0..2^AddrWidth
//   OvfCount_o     out  dropped-sample count (only with DECIM_BUF_OVF_CNT_EN)
//   Overflow_o     out  sticky drop flag
// -----------------------------------------------------------------------------
module decimating_output_buffer #(
  parameter int DataWidth  = 18,
  parameter int AddrWidth  = 4,
  parameter int DecimWidth = 8
) (
  input  logic                         Clk_i,
  input  logic                         Rst_i,
  input  logic signed [DataWidth-1:0]  Data_i,
  input  logic                         DataNd_i,
  input  logic        [DecimWidth-1:0] DecimFactor_i,
  input  logic                         Ready_i,
  input  logic                         ClearOvf_i,
  output logic signed [DataWidth-1:0]  Data_o,
  output logic                         DataValid_o,
  output logic        [AddrWidth:0]    Level_o,
`ifdef DECIM_BUF_OVF_CNT_EN
  output logic        [15:0]           OvfCount_o,
`endif
  output logic                         Overflow_o
);

  localparam int Depth = 1 << AddrWidth;
  localparam logic [AddrWidth:0] DepthCount = {1'b1, {AddrWidth{1'b0}}};

  logic signed [DataWidth-1:0]  r_mem [Depth];
  logic        [AddrWidth-1:0]  r_wptr;
  logic        [AddrWidth-1:0]  r_rptr;
  logic        [AddrWidth:0]    r_count;
  logic        [DecimWidth-1:0] r_phase;
  logic                         r_ovf;

  logic                         w_keep;
  logic                         w_full;
  logic                         w_read;
  logic                         w_write;
  logic                         w_drop;
  logic        [DecimWidth-1:0] w_reload;

  // A strobe landing on phase 0 starts a new decimation period.
  assign w_keep  = DataNd_i && (r_phase == {DecimWidth{1'b0}});
  assign w_full  = (r_count == DepthCount);
  // Read depends only on registered count plus Ready_i, never the reverse.
  assign w_read  = DataValid_o && Ready_i;
  // A read in the same cycle frees the slot being written when full.
  assign w_write = w_keep && (!w_full || w_read);
  assign w_drop  = w_keep && w_full && !w_read;

  // Reload value is max(N,1)-1 so factors 0 and 1 both keep every sample.
  assign w_reload = (DecimFactor_i == {DecimWidth{1'b0}}) ? {DecimWidth{1'b0}}
                  : DecimFactor_i - {{(DecimWidth-1){1'b0}}, 1'b1};

  assign DataValid_o = (r_count != {(AddrWidth+1){1'b0}});
  assign Level_o     = r_count;
  assign Overflow_o  = r_ovf;

  // Decimation phase counter; the factor is only sampled at reload.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_phase <= {DecimWidth{1'b0}};
    end else if (DataNd_i) begin
      if (r_phase == {DecimWidth{1'b0}}) begin
        r_phase <= w_reload;
      end else begin
        r_phase <= r_phase - {{(DecimWidth-1){1'b0}}, 1'b1};
      end
    end else begin
      r_phase <= r_phase;
    end
  end

  // Sample storage; contents intentionally survive reset.
  always_ff @(posedge Clk_i) begin
    if (w_write) begin
      r_mem[r_wptr] <= Data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at 2^AddrWidth.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_wptr  <= {AddrWidth{1'b0}};
      r_rptr  <= {AddrWidth{1'b0}};
      r_count <= {(AddrWidth+1){1'b0}};
    end else begin
      if (w_write) begin
        r_wptr <= r_wptr + {{(AddrWidth-1){1'b0}}, 1'b1};
      end
      if (w_read) begin
        r_rptr <= r_rptr + {{(AddrWidth-1){1'b0}}, 1'b1};
      end
      case ({w_write, w_read})
        2'b10:   r_count <= r_count + {{AddrWidth{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{AddrWidth{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag; a drop wins over a same-cycle clear.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ClearOvf_i) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

`ifdef DECIM_BUF_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  // Saturating drop counter; a drop during a clear restarts the count at 1.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_ovf_cnt <= 16'd0;
    end else if (ClearOvf_i) begin
      r_ovf_cnt <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end else begin
      r_ovf_cnt <= r_ovf_cnt;
    end
  end

  assign OvfCount_o = r_ovf_cnt;
`endif

  // Show-ahead head of queue, masked to zero while empty.
  always_comb begin
    Data_o = {DataWidth{1'b0}};
    if (DataValid_o) begin
      Data_o = r_mem[r_rptr];
    end else begin
      Data_o = {DataWidth{1'b0}};
    end
  end

endmodule

// File: tb/tb_decimating_output_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for decimating_output_buffer: a table of per-cycle vectors
// (inputs applied before an edge, outputs expected just after it), followed
// by a hand-written sequence for ready-while-empty and phase realignment.
// -----------------------------------------------------------------------------
module tb_decimating_output_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] data_in;
  logic        nd;
  logic [7:0]  factor;
  logic        ready;
  logic        clr;
  logic [17:0] data_out;
  logic        valid;
  logic [4:0]  level;
  logic        ovf;
`ifdef DECIM_BUF_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic        rst;
    logic        nd;
    logic [17:0] din;
    logic [7:0]  factor;
    logic        ready;
    logic        clr;
    logic        valid_e;
    logic [17:0] data_e;
    logic [4:0]  level_e;
    logic        ovf_e;
    logic [15:0] cnt_e;
  } vec_t;

  vec_t vecs[$];

  decimating_output_buffer dut (
    .Clk_i         (clk),
    .Rst_i         (rst),
    .Data_i        (data_in),
    .DataNd_i      (nd),
    .DecimFactor_i (factor),
    .Ready_i       (ready),
    .ClearOvf_i    (clr),
    .Data_o        (data_out),
    .DataValid_o   (valid),
    .Level_o       (level),
`ifdef DECIM_BUF_OVF_CNT_EN
    .OvfCount_o    (ovf_cnt),
`endif
    .Overflow_o    (ovf)
  );

  always #5 clk = ~clk;

  function automatic void add(input string tag, input logic r, input logic n,
                              input int d, input int f, input logic rd,
                              input logic c, input logic ve, input int de,
                              input int le, input logic oe, input int ce);
    vec_t v;
    v.tag = tag; v.rst = r; v.nd = n; v.din = 18'(d); v.factor = 8'(f);
    v.ready = rd; v.clr = c; v.valid_e = ve; v.data_e = 18'(de);
    v.level_e = 5'(le); v.ovf_e = oe; v.cnt_e = 16'(ce);
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    logic bad;
    rst = v.rst; nd = v.nd; data_in = v.din; factor = v.factor;
    ready = v.ready; clr = v.clr;
    @(posedge clk);
    #1;
    n_vec++;
    bad = (valid !== v.valid_e) || (data_out !== v.data_e) ||
          (level !== v.level_e) || (ovf !== v.ovf_e);
`ifdef DECIM_BUF_OVF_CNT_EN
    if (ovf_cnt !== v.cnt_e) bad = 1'b1;
`endif
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b data=%0d level=%0d ovf=%0b, want valid=%0b data=%0d level=%0d ovf=%0b (cnt want %0d)",
               v.tag, valid, data_out, level, ovf, v.valid_e, v.data_e,
               v.level_e, v.ovf_e, v.cnt_e);
    end
  endtask

  initial begin
    rst = 1'b1; nd = 1'b0; data_in = 18'd0; factor = 8'd1;
    ready = 1'b0; clr = 1'b0;

    // Reset for 3 cycles, then idle.
    for (int i = 0; i < 3; i++) add("reset", 1'b1, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    add("idle", 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);

    // Decimate by 3: samples 1..9, only 1,4,7 appear (each for one cycle).
    for (int s = 1; s <= 9; s++) begin
      if ((s % 3) == 1) add("dec3_keep", 1'b0, 1'b1, s, 3, 1'b1, 1'b0, 1'b1, s, 1, 1'b0, 0);
      else              add("dec3_skip", 1'b0, 1'b1, s, 3, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    end

    // Factor 0 keeps every sample; same-cycle read/write holds level at 1.
    for (int s = 10; s <= 12; s++) add("fac0", 1'b0, 1'b1, s, 0, 1'b1, 1'b0, 1'b1, s, 1, 1'b0, 0);
    add("fac0_drain", 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);

    // Factor 4, switch to 2 after sample 2: kept 1,5,7,9.
    add("chg_s1", 1'b0, 1'b1, 1, 4, 1'b1, 1'b0, 1'b1, 1, 1, 1'b0, 0);
    add("chg_s2", 1'b0, 1'b1, 2, 4, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    for (int s = 3; s <= 9; s++) begin
      if (s == 5 || s == 7 || s == 9) add("chg_keep", 1'b0, 1'b1, s, 2, 1'b1, 1'b0, 1'b1, s, 1, 1'b0, 0);
      else                            add("chg_skip", 1'b0, 1'b1, s, 2, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    end
    // Phase is 1 here; one discarded strobe realigns it to 0.
    add("realign", 1'b0, 1'b1, 99, 1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);

    // Fill with 100..115, 116 is dropped.
    for (int i = 0; i < 16; i++) add("fill", 1'b0, 1'b1, 100 + i, 1, 1'b0, 1'b0, 1'b1, 100, i + 1, 1'b0, 0);
    add("drop116", 1'b0, 1'b1, 116, 1, 1'b0, 1'b0, 1'b1, 100, 16, 1'b1, 1);
    for (int k = 1; k <= 16; k++)
      add("drain", 1'b0, 1'b0, 0, 1, 1'b1, 1'b0, k < 16, k < 16 ? 100 + k : 0, 16 - k, 1'b1, 1);
    add("clear", 1'b0, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0);

    // Full with simultaneous read and write: no drop, 216 is stored.
    for (int i = 0; i < 16; i++) add("fill2", 1'b0, 1'b1, 200 + i, 1, 1'b0, 1'b0, 1'b1, 200, i + 1, 1'b0, 0);
    add("full_rw", 1'b0, 1'b1, 216, 1, 1'b1, 1'b0, 1'b1, 201, 16, 1'b0, 0);
    for (int k = 1; k <= 16; k++)
      add("drain2", 1'b0, 1'b0, 0, 1, 1'b1, 1'b0, k < 16, k < 16 ? 201 + k : 0, 16 - k, 1'b0, 0);

    // Overflow, then drop colliding with clear: flag stays, count restarts at 1.
    for (int i = 0; i < 16; i++) add("fill3", 1'b0, 1'b1, 300 + i, 1, 1'b0, 1'b0, 1'b1, 300, i + 1, 1'b0, 0);
    add("drop316", 1'b0, 1'b1, 316, 1, 1'b0, 1'b0, 1'b1, 300, 16, 1'b1, 1);
    add("drop317", 1'b0, 1'b1, 317, 1, 1'b0, 1'b0, 1'b1, 300, 16, 1'b1, 2);
    add("drop_clr", 1'b0, 1'b1, 318, 1, 1'b0, 1'b1, 1'b1, 300, 16, 1'b1, 1);

    // Drain to level 5, then reset mid-stream.
    for (int k = 1; k <= 11; k++)
      add("drain3", 1'b0, 1'b0, 0, 1, 1'b1, 1'b0, 1'b1, 300 + k, 16 - k, 1'b1, 1);
    add("rst_mid", 1'b1, 1'b0, 0, 3, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    add("post_rst_keep", 1'b0, 1'b1, 400, 3, 1'b0, 1'b0, 1'b1, 400, 1, 1'b0, 0);
    add("post_rst_skip", 1'b0, 1'b1, 401, 3, 1'b0, 1'b0, 1'b1, 400, 1, 1'b0, 0);
    add("post_rst_read", 1'b0, 1'b0, 0, 3, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Hand sequence: Ready_i while empty moves nothing; phase is 1 here.
    begin
      vec_t v;
      v.rst = 1'b0; v.clr = 1'b0; v.factor = 8'd1; v.ovf_e = 1'b0; v.cnt_e = 16'd0;
      for (int i = 0; i < 3; i++) begin
        v.tag = "empty_ready"; v.nd = 1'b0; v.din = 18'd0; v.ready = 1'b1;
        v.valid_e = 1'b0; v.data_e = 18'd0; v.level_e = 5'd0;
        apply(v);
      end
      v.tag = "hs_skip499"; v.nd = 1'b1; v.din = 18'd499; v.ready = 1'b0;
      v.valid_e = 1'b0; v.data_e = 18'd0; v.level_e = 5'd0;
      apply(v);
      v.tag = "hs_keep500"; v.din = 18'd500;
      v.valid_e = 1'b1; v.data_e = 18'd500; v.level_e = 5'd1;
      apply(v);
      v.tag = "hs_keep501"; v.din = 18'd501; v.level_e = 5'd2;
      apply(v);
      v.tag = "hs_read500"; v.nd = 1'b0; v.ready = 1'b1;
      v.data_e = 18'd501; v.level_e = 5'd1;
      apply(v);
      v.tag = "hs_read501";
      v.valid_e = 1'b0; v.data_e = 18'd0; v.level_e = 5'd0;
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/decimating_output_buffer.md
# decimating_output_buffer

Output stage placed directly after the symmetric-round stage of the systolic symmetric FIR. It takes the rounded 18-bit samples and their new-data strobes, keeps every N-th sample (runtime decimation factor), and stores kept samples in a small FIFO. The downstream consumer drains the FIFO with a valid/ready handshake. Samples that arrive while the FIFO is full are dropped and reported.

## Interface
- DataWidth, 18, sample width; matches the round-stage output width
- AddrWidth, 4, FIFO address width; depth = 2^AddrWidth (16)
- DecimWidth, 8, width of the decimation factor input

Ports:
- Clk_i  in  1  clock; all logic on the rising edge
- Rst_i  in  1  synchronous, active-high reset
- Data_i  in  DataWidth  signed sample from the round stage
- DataNd_i  in  1  new-data strobe; Data_i is valid while high
- DecimFactor_i  in  DecimWidth  decimation factor N; 0 and 1 both mean keep every sample
- Ready_i  in  1  downstream ready
- ClearOvf_i  in  1  clears Overflow_o (and OvfCount_o when configured)
- Data_o  out  DataWidth  FIFO head sample; forced to 0 whenever DataValid_o is low
- DataValid_o  out  1  FIFO not empty
- Level_o  out  AddrWidth+1  current FIFO occupancy, 0..2^AddrWidth
- Overflow_o  out  1  sticky flag: a kept sample was dropped

## Operation
- **Decimator:** down-counter `phase` (DecimWidth bits), reset to 0.
  - When DataNd_i is high and phase==0: the sample is kept, and phase reloads to max(DecimFactor_i,1)-1.
  - When DataNd_i is high and phase!=0: the sample is discarded, and phase decrements.
  - When DataNd_i is low: no change.
  - The first sample after reset is always kept.
  - DecimFactor_i is sampled only at reload. A change mid-period takes effect after the current period ends.
- **FIFO:** show-ahead, with write pointer, read pointer and an occupancy count (AddrWidth+1 bits).
  - Write happens when a sample is kept and (count < depth, or a read occurs in the same cycle).
  - Read happens when DataValid_o && Ready_i.
  - Pointers wrap modulo depth.
  - Write and read in the same cycle: count is unchanged.
  - Write and read in the same cycle when full: the write is accepted and count stays at depth.
  - Ready_i while empty: ignored, with no pointer movement.
- **Overflow:**
  - A kept sample that arrives while full with no same-cycle read is dropped, and Overflow_o sets on the next cycle.
  - ClearOvf_i clears the flag.
  - A drop in the same cycle as ClearOvf_i leaves the flag set (the set wins).
- **Reset:** Rst_i clears phase, pointers, count, Overflow_o (and OvfCount_o). The FIFO contents are not cleared. Reset asserted mid-stream discards all buffered samples.

## Timing
- Reset values: Data_o=0, DataValid_o=0, Level_o=0, Overflow_o=0 (OvfCount_o=0).
- Latency: a sample kept at edge k appears on Data_o with DataValid_o=1 after edge k, i.e. it is visible in cycle k+1. Level_o updates in the same cycle.
- Handshake: a transfer occurs on an edge where DataValid_o && Ready_i. Data_o advances to the next entry in the following cycle.
- Full-rate draining with Ready_i held high sustains 1 sample/cycle.
- Overflow_o rises one cycle after the dropping edge and falls one cycle after a ClearOvf_i edge.
- All outputs are registered or are decoded from registered state plus the memory read. No combinational path runs from Ready_i to DataValid_o.

## Configuration
- Macro `DECIM_BUF_OVF_CNT_EN`.
- **Defined:** adds port OvfCount_o (out, 16 bits), counting dropped samples.
  - Increments by 1 per drop and saturates at 0xFFFF.
  - Cleared by ClearOvf_i; a drop in the same cycle as the clear leaves the count at 1.
  - Reset value 0.
- **Undefined:** the port and counter are absent. Overflow_o behaviour is identical in both builds.

## Test plan
- **Reset/idle:** Rst_i for 3 cycles, then idle → Data_o=0, DataValid_o=0, Level_o=0, Overflow_o=0.
- **Decimate by 3:** DecimFactor_i=3, Ready_i=1, samples 1..9 on consecutive DataNd_i → output sequence 1,4,7 only; each appears one cycle after its input.
- **Factor 0 and change mid-period:**
  - DecimFactor_i=0 → every sample kept.
  - With factor 4, switch to 2 after sample 2 → kept samples 1,5,7,9.
- **Fill/overflow:** Ready_i=0, factor 1, write 17 samples (values 100..116) → Level_o=16; sample 116 dropped; Overflow_o=1 next cycle (OvfCount_o=1 if configured). Then Ready_i=1 → drains 100..115 in order and DataValid_o falls after 115.
- **Full with simultaneous read/write:** FIFO full, Ready_i=1, and a kept sample in the same cycle → no drop, Level_o stays 16, Overflow_o stays 0.
- **Clear collision and reset mid-stream:**
  - Drop and ClearOvf_i in the same cycle → Overflow_o remains 1.
  - Rst_i with Level_o=5 → next cycle Level_o=0 and DataValid_o=0; the first post-reset sample is kept.
